// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction codes, special register IDs and the
// writeback sequencer state encoding used by sequential and pipelined control.
package y86_pkg;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_CMOVXX = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [3:0] REG_RSP  = 4'h4;
    localparam logic [3:0] REG_NONE = 4'hF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR_E = 2'd1,
        WR_M = 2'd2,
        DONE = 2'd3
    } wb_state_t;

endpackage

// File: rtl/y86_dst_decode.sv
// Combinational destination-register decode for the E and M writeback ports.
// Codes above popq have no defined semantics and are flagged illegal.
module y86_dst_decode
    import y86_pkg::*;
#(
    parameter logic [3:0] RSP_ID  = REG_RSP,
    parameter logic [3:0] NONE_ID = REG_NONE
) (
    input  logic [3:0] icode,
    input  logic       cnd,
    input  logic [3:0] rA,
    input  logic [3:0] rB,
    output logic [3:0] dst_e,
    output logic [3:0] dst_m,
    output logic       illegal
);

    always_comb begin
        dst_e   = NONE_ID;
        dst_m   = NONE_ID;
        illegal = 1'b0;
        case (icode)
            I_CMOVXX:                  dst_e = cnd ? rB : NONE_ID;
            I_IRMOVQ, I_OPQ:           dst_e = rB;
            I_MRMOVQ:                  dst_m = rA;
            I_CALL, I_RET, I_PUSHQ:    dst_e = RSP_ID;
            I_POPQ: begin
                dst_e = RSP_ID;
                dst_m = rA;
            end
            I_HALT, I_NOP, I_RMMOVQ, I_JXX: ;
            default:                   illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/y86_wb_sequencer.sv
// Writeback sequencer: serialises the E and M results of one retiring
// instruction onto the single register-file write port, E first.
module y86_wb_sequencer
    import y86_pkg::*;
#(
    parameter int          DATA_W  = 64,
    parameter logic [3:0]  RSP_ID  = 4'h4,
    parameter logic [3:0]  NONE_ID = 4'hF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        icode,
    input  logic              cnd,
    input  logic [3:0]        rA,
    input  logic [3:0]        rB,
    input  logic [DATA_W-1:0] valE,
    input  logic [DATA_W-1:0] valM,
    output logic              wr_en,
    output logic [3:0]        wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              wb_done,
    output logic              wb_err
);

    wb_state_t state, state_next;

    logic [3:0]        dst_e, dst_m;
    logic              illegal;
    logic              accept;

    logic [3:0]        dst_e_p0, dst_m_p0;
    logic [DATA_W-1:0] val_e_p0, val_m_p0;
    logic              err_p0;

    y86_dst_decode #(
        .RSP_ID  (RSP_ID),
        .NONE_ID (NONE_ID)
    ) u_dst_decode (
        .icode   (icode),
        .cnd     (cnd),
        .rA      (rA),
        .rB      (rB),
        .dst_e   (dst_e),
        .dst_m   (dst_m),
        .illegal (illegal)
    );

    assign accept = (state == IDLE) && in_valid;

    // Stage p0: instruction latched on accept, held for the whole sequence
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            dst_e_p0 <= NONE_ID;
            dst_m_p0 <= NONE_ID;
            err_p0   <= 1'b0;
            val_e_p0 <= '0;
            val_m_p0 <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                dst_e_p0 <= dst_e;
                dst_m_p0 <= dst_m;
                err_p0   <= illegal;
                val_e_p0 <= valE;
                val_m_p0 <= valM;
            end
        end
    end

    // Next-state decisions look at the live decode in IDLE, the latched copy after
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    if (dst_e != NONE_ID)      state_next = WR_E;
                    else if (dst_m != NONE_ID) state_next = WR_M;
                    else                       state_next = DONE;
                end
            end
            WR_E:    state_next = (dst_m_p0 != NONE_ID) ? WR_M : DONE;
            WR_M:    state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready = 1'b0;
        wr_en    = 1'b0;
        wr_addr  = NONE_ID;
        wr_data  = '0;
        wb_done  = 1'b0;
        wb_err   = 1'b0;
        case (state)
            IDLE: in_ready = 1'b1;
            WR_E: begin
                wr_en   = 1'b1;
                wr_addr = dst_e_p0;
                wr_data = val_e_p0;
            end
            WR_M: begin
                wr_en   = 1'b1;
                wr_addr = dst_m_p0;
                wr_data = val_m_p0;
            end
            DONE: begin
                wb_done = 1'b1;
                wb_err  = err_p0;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_y86_wb_sequencer.sv
// Directed bench for the writeback sequencer with a small register-file model.
module tb_y86_wb_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  icode;
    logic        cnd;
    logic [3:0]  rA, rB;
    logic [63:0] valE, valM;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [63:0] wr_data;
    logic        wb_done;
    logic        wb_err;

    int errors = 0;
    int checks = 0;
    int done_cnt = 0;
    int acc_cnt = 0;
    logic [63:0] regs [16];

    always #5 clk = ~clk;

    y86_wb_sequencer #(.DATA_W(64), .RSP_ID(4'h4), .NONE_ID(4'hF)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .icode(icode), .cnd(cnd), .rA(rA), .rB(rB), .valE(valE), .valM(valM),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wb_done(wb_done), .wb_err(wb_err)
    );

    // register file and event counters
    always @(posedge clk) begin
        if (wr_en) regs[wr_addr] <= wr_data;
        if (wb_done) done_cnt++;
        if (in_valid && in_ready && !reset) acc_cnt++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [3:0] ic, input logic c, input logic [3:0] a,
                           input logic [3:0] b, input logic [63:0] e, input logic [63:0] m);
        icode = ic; cnd = c; rA = a; rB = b; valE = e; valM = m;
        in_valid = 1'b1;
    endtask

    // present, wait (bounded) for IDLE, take the accept edge, drop in_valid
    task automatic issue(input logic [3:0] ic, input logic c, input logic [3:0] a,
                         input logic [3:0] b, input logic [63:0] e, input logic [63:0] m);
        int n;
        n = 0;
        present(ic, c, a, b, e, m);
        while (!in_ready && n < 20) begin
            step();
            n++;
        end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL issue_timeout: in_ready=%b want 1", in_ready); end
        step();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0;
        present(4'h0, 1'b0, 4'h0, 4'h0, 64'd0, 64'd0);
        in_valid = 1'b0;
        step(); step();
        reset = 1'b0;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
        checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL rst_wr_en: got %b want 0", wr_en); end
        checks++; if (wr_addr !== 4'hF) begin errors++; $display("FAIL rst_wr_addr: got %h want f", wr_addr); end
        checks++; if (wr_data !== 64'd0) begin errors++; $display("FAIL rst_wr_data: got %0d want 0", wr_data); end
        checks++; if (wb_done !== 1'b0 || wb_err !== 1'b0) begin errors++; $display("FAIL rst_done: got %b/%b want 0/0", wb_done, wb_err); end
    endtask

    task automatic test_reset_mid_popq();
        int snap_done, snap_acc;
        issue(4'hB, 1'b0, 4'h3, 4'hF, 64'd262, 64'd77);
        checks++; if (wr_en !== 1'b1 || wr_addr !== 4'h4) begin errors++; $display("FAIL rmid_wre: got en=%b addr=%h want 1/4", wr_en, wr_addr); end
        snap_done = done_cnt;
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rmid_in_ready: got %b want 1", in_ready); end
        checks++; if (wr_en !== 1'b0 || wr_addr !== 4'hF) begin errors++; $display("FAIL rmid_wr: got en=%b addr=%h want 0/f", wr_en, wr_addr); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (wr_en !== 1'b0 || wb_done !== 1'b0) begin errors++; $display("FAIL rmid_quiet%0d: got en=%b done=%b want 0/0", i, wr_en, wb_done); end
            step();
        end
        checks++; if (done_cnt !== snap_done) begin errors++; $display("FAIL rmid_done_cnt: got %0d want %0d", done_cnt, snap_done); end
        checks++; if (regs[3] !== 64'd0) begin errors++; $display("FAIL rmid_rbx: got %0d want 0", regs[3]); end
        // reset coinciding with in_valid must not accept
        snap_acc = acc_cnt;
        present(4'h3, 1'b0, 4'hF, 4'h5, 64'd1, 64'd0);
        reset = 1'b1;
        step();
        reset = 1'b0; in_valid = 1'b0;
        checks++; if (in_ready !== 1'b1 || wr_en !== 1'b0) begin errors++; $display("FAIL rst_valid: got rdy=%b en=%b want 1/0", in_ready, wr_en); end
        checks++; if (acc_cnt !== snap_acc) begin errors++; $display("FAIL rst_valid_acc: got %0d want %0d", acc_cnt, snap_acc); end
    endtask

    task automatic test_popq();
        issue(4'hB, 1'b0, 4'h3, 4'hF, 64'd262, 64'd77);
        checks++; if (wr_en !== 1'b1 || wr_addr !== 4'h4 || wr_data !== 64'd262) begin errors++; $display("FAIL popq_e: got %b/%h/%0d want 1/4/262", wr_en, wr_addr, wr_data); end
        checks++; if (in_ready !== 1'b0 || wb_done !== 1'b0) begin errors++; $display("FAIL popq_busy: got rdy=%b done=%b want 0/0", in_ready, wb_done); end
        step();
        checks++; if (wr_en !== 1'b1 || wr_addr !== 4'h3 || wr_data !== 64'd77) begin errors++; $display("FAIL popq_m: got %b/%h/%0d want 1/3/77", wr_en, wr_addr, wr_data); end
        step();
        checks++; if (wr_en !== 1'b0 || wr_addr !== 4'hF || wr_data !== 64'd0) begin errors++; $display("FAIL popq_idle_port: got %b/%h/%0d want 0/f/0", wr_en, wr_addr, wr_data); end
        checks++; if (wb_done !== 1'b1 || wb_err !== 1'b0) begin errors++; $display("FAIL popq_done: got %b/%b want 1/0", wb_done, wb_err); end
        step();
        checks++; if (in_ready !== 1'b1 || wb_done !== 1'b0) begin errors++; $display("FAIL popq_ready: got rdy=%b done=%b want 1/0", in_ready, wb_done); end
        checks++; if (regs[4] !== 64'd262 || regs[3] !== 64'd77) begin errors++; $display("FAIL popq_regs: got rsp=%0d rbx=%0d want 262/77", regs[4], regs[3]); end
        // popq %rsp: M write lands last
        issue(4'hB, 1'b0, 4'h4, 4'hF, 64'd262, 64'd99);
        checks++; if (wr_addr !== 4'h4 || wr_data !== 64'd262) begin errors++; $display("FAIL poprsp_e: got %h/%0d want 4/262", wr_addr, wr_data); end
        step();
        checks++; if (wr_addr !== 4'h4 || wr_data !== 64'd99) begin errors++; $display("FAIL poprsp_m: got %h/%0d want 4/99", wr_addr, wr_data); end
        step(); step();
        checks++; if (regs[4] !== 64'd99) begin errors++; $display("FAIL poprsp_final: got %0d want 99", regs[4]); end
    endtask

    task automatic test_cmov();
        issue(4'h2, 1'b0, 4'h1, 4'h2, 64'd55, 64'd0);
        checks++; if (wr_en !== 1'b0 || wb_done !== 1'b1) begin errors++; $display("FAIL cmov0: got en=%b done=%b want 0/1", wr_en, wb_done); end
        step();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL cmov0_ready: got %b want 1", in_ready); end
        issue(4'h2, 1'b1, 4'h1, 4'h2, 64'd55, 64'd0);
        checks++; if (wr_en !== 1'b1 || wr_addr !== 4'h2 || wr_data !== 64'd55) begin errors++; $display("FAIL cmov1_wr: got %b/%h/%0d want 1/2/55", wr_en, wr_addr, wr_data); end
        step();
        checks++; if (wr_en !== 1'b0 || wb_done !== 1'b1) begin errors++; $display("FAIL cmov1_done: got en=%b done=%b want 0/1", wr_en, wb_done); end
        step();
    endtask

    task automatic test_illegal();
        issue(4'hD, 1'b0, 4'h1, 4'h2, 64'd5, 64'd6);
        checks++; if (wr_en !== 1'b0 || wb_done !== 1'b1 || wb_err !== 1'b1) begin errors++; $display("FAIL illegal: got en=%b done=%b err=%b want 0/1/1", wr_en, wb_done, wb_err); end
        step();
        checks++; if (wb_err !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL illegal_after: got err=%b rdy=%b want 0/1", wb_err, in_ready); end
        issue(4'h4, 1'b0, 4'h1, 4'h2, 64'd5, 64'd6);
        checks++; if (wr_en !== 1'b0 || wb_done !== 1'b1 || wb_err !== 1'b0) begin errors++; $display("FAIL rmmovq: got en=%b done=%b err=%b want 0/1/0", wr_en, wb_done, wb_err); end
        step();
    endtask

    task automatic test_back_to_back();
        logic [3:0]  ic_t [3];
        logic [3:0]  rb_t [3];
        logic [63:0] ve_t [3];
        logic [3:0]  ad_t [3];
        int base_done, base_acc;
        ic_t = '{4'h3, 4'h6, 4'h8};
        rb_t = '{4'h7, 4'h0, 4'hF};
        ve_t = '{64'd10000, 64'd12, 64'd246};
        ad_t = '{4'h7, 4'h0, 4'h4};
        base_done = done_cnt;
        base_acc = acc_cnt;
        for (int i = 0; i < 3; i++) begin
            present(ic_t[i], 1'b0, 4'hF, rb_t[i], ve_t[i], 64'd0);
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready%0d: got %b want 1", i, in_ready); end
            step();
            checks++; if (wr_en !== 1'b1 || wr_addr !== ad_t[i] || wr_data !== ve_t[i] || in_ready !== 1'b0) begin
                errors++; $display("FAIL b2b_wr%0d: got %b/%h/%0d rdy=%b want 1/%h/%0d rdy=0", i, wr_en, wr_addr, wr_data, in_ready, ad_t[i], ve_t[i]);
            end
            step();
            checks++; if (wb_done !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL b2b_done%0d: got done=%b rdy=%b want 1/0", i, wb_done, in_ready); end
            if (i == 2) in_valid = 1'b0;
            step();
        end
        checks++; if (acc_cnt - base_acc !== 3) begin errors++; $display("FAIL b2b_accepts: got %0d want 3", acc_cnt - base_acc); end
        checks++; if (done_cnt - base_done !== 3) begin errors++; $display("FAIL b2b_dones: got %0d want 3", done_cnt - base_done); end
        checks++; if (regs[7] !== 64'd10000 || regs[0] !== 64'd12 || regs[4] !== 64'd246) begin
            errors++; $display("FAIL b2b_regs: got %0d/%0d/%0d want 10000/12/246", regs[7], regs[0], regs[4]);
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) regs[i] = 64'd0;
        test_reset();
        test_reset_mid_popq();
        test_popq();
        test_cmov();
        test_illegal();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/y86_wb_sequencer.md
# y86_wb_sequencer

Writeback sequencer for the sequential Y86-64 core's register file, which has a single write port. It accepts one retiring instruction (icode, ifun-derived cnd, rA, rB, valE, valM) per handshake. It derives the E and M destination registers and issues up to two writes, one per cycle, on the register file write port. It sits between the execute/memory stages and the register file, and signals the PC-update/fetch control when writeback is complete.

## Interface
Parameters:
- DATA_W, 64, register/data width
- RSP_ID, 4'h4, register ID of %rsp
- NONE_ID, 4'hF, "no register" ID

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high
- in_valid  in  1  retiring instruction presented
- in_ready  out  1  sequencer can accept; high only in IDLE
- icode  in  4  instruction code
- cnd  in  1  condition result (used by cmovXX only)
- rA, rB  in  4 each  register specifiers from fetch
- valE  in  DATA_W  ALU result
- valM  in  DATA_W  memory read value
- wr_en  out  1  register file write strobe
- wr_addr  out  4  write register ID
- wr_data  out  DATA_W  write data
- wb_done  out  1  one-cycle pulse: instruction writeback finished
- wb_err  out  1  valid only with wb_done: icode was illegal (0xC–0xF)

## Operation
- Accept on the rising edge where in_valid && in_ready. On accept, latch valE, valM and the computed dstE/dstM. Ignore inputs otherwise.
- Destination rules (ID NONE_ID = no write):
  - 2 cmovXX: dstE = cnd ? rB : NONE
  - 3 irmovq: dstE = rB
  - 6 OPq: dstE = rB
  - 5 mrmovq: dstM = rA
  - 8 call, 9 ret, A pushq: dstE = RSP_ID
  - B popq: dstE = RSP_ID, dstM = rA
  - 0 halt, 1 nop, 4 rmmovq, 7 jXX: no writes
  - 0xC–0xF: no writes; latch err = 1
- FSM states:
  - IDLE: accept → WR_E if dstE≠NONE, else WR_M if dstM≠NONE, else DONE
  - WR_E: wr_en=1, wr_addr=dstE, wr_data=valE → WR_M if dstM≠NONE, else DONE
  - WR_M: wr_en=1, wr_addr=dstM, wr_data=valM → DONE
  - DONE: wb_done=1, wb_err=err → IDLE
- Ordering is always E before M. popq %rsp therefore leaves %rsp = valM (M wins). popq with rA=NONE performs only the E write.
- Outputs are decoded from registered state and latches only; there is no combinational input→output path.
- When not writing: wr_en=0, wr_addr=NONE_ID, wr_data=0.

## Timing
- Reset values: state=IDLE, in_ready=1 after the reset edge, wr_en=0, wr_addr=4'hF, wr_data=0, wb_done=0, wb_err=0, latches cleared.
- Reset asserted mid-sequence: abort on that edge, with no further writes and no wb_done. A reset coinciding with in_valid is not an accept.
- Latency from the accept edge T:
  - Two writes (popq): WR_E at T+1, WR_M at T+2, wb_done at T+3, next accept at T+4.
  - One write: write at T+1, wb_done at T+2, next accept at T+3.
  - Zero writes or illegal icode: wb_done at T+1, next accept at T+2.
- in_ready is low from T+1 until IDLE is re-entered. Holding in_valid high produces back-to-back accepts at those boundaries only.
- wb_err is meaningful only in the wb_done cycle; it is 0 otherwise.

## Structure
- Shared package y86_pkg holds:
  - icode localparams (I_HALT…I_POPQ)
  - REG_RSP and REG_NONE constants
  - wb_state_t enum (IDLE, WR_E, WR_M, DONE), shared with future pipeline control
- One sub-module, y86_dst_decode: combinational icode/cnd/rA/rB → dstE, dstM, illegal. It is reused later by the pipelined hazard unit.

## Test plan
- Reset mid-popq (assert reset in WR_E cycle) → no WR_M write, no wb_done; in_ready=1 after reset; wr_addr=4'hF.
- popq rA=3 (%rbx), valE=262, valM=77 → T+1 write (4, 262), T+2 write (3, 77), wb_done at T+3, wb_err=0.
- popq rA=4, valE=262, valM=99 → writes (4,262) then (4,99); final %rsp model = 99.
- cmovXX rB=2, valE=55: cnd=0 → no writes, wb_done at T+1; cnd=1 → write (2,55) at T+1, wb_done at T+2.
- icode=0xD → no wr_en, wb_done at T+1 with wb_err=1; following rmmovq → wb_done with wb_err=0, no writes.
- Back-to-back stream with in_valid held high (irmovq rB=7 valE=10000, OPq rB=0 valE=12, call valE=246) → accepts exactly at IDLE cycles; writes (7,10000), (0,12), (4,246) in order; three wb_done pulses.
